ysyx_22040750_axi_arb: RTL and testbench

Two-master to one-slave AXI-lite style arbiter that shares the CLINT/peripheral slave port between the IFU (M0, read-only) and the LSU (M1, read/write).
- Sits between the pipeline front/back-end bus masters and the downstream slave.
- Serialises all traffic: one transaction in flight at a time.
- Round-robin arbitration on reads; writes take priority over reads.

---
 rtl/ysyx_22040750_axi_arb.sv | 167 ++++++++++++++++
 tb/tb_ysyx_22040750_axi_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_axi_arb.sv
// ysyx_22040750_axi_arb: shares one AXI-lite slave between the IFU (read) and LSU (read/write),
// one transaction in flight, round-robin reads, writes ahead of reads.
module ysyx_22040750_axi_arb #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int SW = 8
) (
    input  logic          I_clk,
    input  logic          I_rst,
    input  logic [AW-1:0] I_m0_araddr,
    input  logic          I_m0_arvalid,
    output logic          O_m0_arready,
    output logic [DW-1:0] O_m0_rdata,
    output logic          O_m0_rvalid,
    input  logic          I_m0_rready,
    input  logic [AW-1:0] I_m1_araddr,
    input  logic          I_m1_arvalid,
    output logic          O_m1_arready,
    output logic [DW-1:0] O_m1_rdata,
    output logic          O_m1_rvalid,
    input  logic          I_m1_rready,
    input  logic [AW-1:0] I_m1_awaddr,
    input  logic          I_m1_awvalid,
    output logic          O_m1_awready,
    input  logic [DW-1:0] I_m1_wdata,
    input  logic [SW-1:0] I_m1_wstrb,
    input  logic          I_m1_wvalid,
    output logic          O_m1_wready,
    output logic          O_m1_bvalid,
    input  logic          I_m1_bready,
    output logic [AW-1:0] O_s_araddr,
    output logic          O_s_arvalid,
    input  logic          I_s_arready,
    input  logic [DW-1:0] I_s_rdata,
    input  logic          I_s_rvalid,
    output logic          O_s_rready,
    output logic [AW-1:0] O_s_awaddr,
    output logic          O_s_awvalid,
    input  logic          I_s_awready,
    output logic [DW-1:0] O_s_wdata,
    output logic [SW-1:0] O_s_wstrb,
    output logic          O_s_wvalid,
    input  logic          I_s_wready,
    input  logic          I_s_bvalid,
    output logic          O_s_bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_B} wstate_t;
    rstate_t r_rs, w_rs_nx;
    wstate_t r_ws, w_ws_nx;
    logic r_last, r_grant, r_b_hold, r_rst_d;
    logic w_last_nx, w_grant_nx, w_b_hold_nx, w_live, w_gnt, w_rready;
    logic [AW-1:0] r_araddr, r_awaddr, w_araddr_nx, w_awaddr_nx;

    // handshakes stay masked during reset and the cycle after it
    assign w_live = !(I_rst || r_rst_d);
    assign w_gnt = (I_m0_arvalid && I_m1_arvalid) ? !r_last : I_m1_arvalid;
    assign O_s_araddr = r_araddr;
    assign O_s_awaddr = r_awaddr;
    assign O_s_wdata = I_m1_wdata;
    assign O_s_wstrb = I_m1_wstrb;

    always_ff @(posedge I_clk) begin
        r_rst_d <= I_rst;
        if (I_rst) begin
            r_rs <= R_IDLE;
            r_ws <= W_IDLE;
            r_last <= 1'b1;
            r_grant <= 1'b0;
            r_b_hold <= 1'b0;
            r_araddr <= '0;
            r_awaddr <= '0;
        end else begin
            r_rs <= w_rs_nx;
            r_ws <= w_ws_nx;
            r_last <= w_last_nx;
            r_grant <= w_grant_nx;
            r_b_hold <= w_b_hold_nx;
            r_araddr <= w_araddr_nx;
            r_awaddr <= w_awaddr_nx;
        end
    end

    always_comb begin
        w_rs_nx = r_rs;
        w_ws_nx = r_ws;
        w_last_nx = r_last;
        w_grant_nx = r_grant;
        w_b_hold_nx = r_b_hold;
        w_araddr_nx = r_araddr;
        w_awaddr_nx = r_awaddr;
        w_rready = 1'b0;
        O_m0_arready = 1'b0;
        O_m1_arready = 1'b0;
        O_m0_rvalid = 1'b0;
        O_m1_rvalid = 1'b0;
        O_m0_rdata = '0;
        O_m1_rdata = '0;
        O_s_arvalid = 1'b0;
        O_s_rready = 1'b0;
        O_m1_awready = 1'b0;
        O_s_awvalid = 1'b0;
        O_s_wvalid = 1'b0;
        O_m1_wready = 1'b0;
        O_s_bready = 1'b0;
        O_m1_bvalid = 1'b0;
        if (w_live) begin
            case (r_rs)
                R_IDLE: if (r_ws == W_IDLE && !I_m1_awvalid && (I_m0_arvalid || I_m1_arvalid)) begin
                    O_m0_arready = !w_gnt;
                    O_m1_arready = w_gnt;
                    w_grant_nx = w_gnt;
                    w_araddr_nx = w_gnt ? I_m1_araddr : I_m0_araddr;
                    w_rs_nx = R_AR;
                end
                R_AR: begin
                    O_s_arvalid = 1'b1;
                    w_rs_nx = I_s_arready ? R_DATA : R_AR;
                end
                R_DATA: begin
                    w_rready = r_grant ? I_m1_rready : I_m0_rready;
                    O_s_rready = w_rready;
                    O_m0_rvalid = !r_grant && I_s_rvalid;
                    O_m1_rvalid = r_grant && I_s_rvalid;
                    O_m0_rdata = r_grant ? '0 : I_s_rdata;
                    O_m1_rdata = r_grant ? I_s_rdata : '0;
                    if (I_s_rvalid && w_rready) begin
                        w_last_nx = r_grant;
                        w_rs_nx = R_IDLE;
                    end
                end
                default: w_rs_nx = R_IDLE;
            endcase
            case (r_ws)
                W_IDLE: begin
                    O_m1_awready = r_rs == R_IDLE;
                    if (r_rs == R_IDLE && I_m1_awvalid) begin
                        w_awaddr_nx = I_m1_awaddr;
                        w_ws_nx = W_AW;
                    end
                end
                W_AW: begin
                    O_s_awvalid = 1'b1;
                    w_ws_nx = I_s_awready ? W_W : W_AW;
                end
                W_W: begin
                    O_s_wvalid = I_m1_wvalid;
                    O_m1_wready = I_s_wready;
                    O_s_bready = 1'b1;
                    if (I_m1_wvalid && I_s_wready) begin
                        w_ws_nx = W_B;
                        w_b_hold_nx = I_s_bvalid;
                    end
                end
                W_B: begin
                    O_s_bready = !r_b_hold;
                    O_m1_bvalid = r_b_hold;
                    w_b_hold_nx = r_b_hold || I_s_bvalid;
                    if (I_m1_bready && r_b_hold) begin
                        w_b_hold_nx = 1'b0;
                        w_ws_nx = W_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_22040750_axi_arb.sv
// tb_ysyx_22040750_axi_arb: scoreboard bench for the IFU/LSU AXI-lite arbiter
// against a small CLINT-like slave with registered read data.
module tb_ysyx_22040750_axi_arb;
    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic [31:0] I_m0_araddr = '0, I_m1_araddr = '0, I_m1_awaddr = '0;
    logic        I_m0_arvalid = 1'b0, I_m1_arvalid = 1'b0, I_m0_rready = 1'b1, I_m1_rready = 1'b1;
    logic        I_m1_awvalid = 1'b0, I_m1_wvalid = 1'b0, I_m1_bready = 1'b1;
    logic [63:0] I_m1_wdata = '0;
    logic [7:0]  I_m1_wstrb = '0;
    logic        O_m0_arready, O_m1_arready, O_m0_rvalid, O_m1_rvalid, O_m1_awready, O_m1_wready, O_m1_bvalid;
    logic [63:0] O_m0_rdata, O_m1_rdata, O_s_wdata;
    logic [31:0] O_s_araddr, O_s_awaddr;
    logic [7:0]  O_s_wstrb;
    logic        O_s_arvalid, O_s_rready, O_s_awvalid, O_s_wvalid, O_s_bready;
    logic        I_s_arready = 1'b1, I_s_awready = 1'b1, I_s_wready = 1'b1;
    logic        I_s_rvalid, I_s_bvalid;
    logic [63:0] I_s_rdata;
    logic        s_hold = 1'b0;
    logic [63:0] mem [16];

    typedef struct {bit m; logic [63:0] d;} exp_t;
    exp_t rq[$];
    int n_vec = 0, n_err = 0;

    ysyx_22040750_axi_arb dut (
        .I_clk(I_clk), .I_rst(I_rst),
        .I_m0_araddr(I_m0_araddr), .I_m0_arvalid(I_m0_arvalid), .O_m0_arready(O_m0_arready),
        .O_m0_rdata(O_m0_rdata), .O_m0_rvalid(O_m0_rvalid), .I_m0_rready(I_m0_rready),
        .I_m1_araddr(I_m1_araddr), .I_m1_arvalid(I_m1_arvalid), .O_m1_arready(O_m1_arready),
        .O_m1_rdata(O_m1_rdata), .O_m1_rvalid(O_m1_rvalid), .I_m1_rready(I_m1_rready),
        .I_m1_awaddr(I_m1_awaddr), .I_m1_awvalid(I_m1_awvalid), .O_m1_awready(O_m1_awready),
        .I_m1_wdata(I_m1_wdata), .I_m1_wstrb(I_m1_wstrb), .I_m1_wvalid(I_m1_wvalid), .O_m1_wready(O_m1_wready),
        .O_m1_bvalid(O_m1_bvalid), .I_m1_bready(I_m1_bready),
        .O_s_araddr(O_s_araddr), .O_s_arvalid(O_s_arvalid), .I_s_arready(I_s_arready),
        .I_s_rdata(I_s_rdata), .I_s_rvalid(I_s_rvalid), .O_s_rready(O_s_rready),
        .O_s_awaddr(O_s_awaddr), .O_s_awvalid(O_s_awvalid), .I_s_awready(I_s_awready),
        .O_s_wdata(O_s_wdata), .O_s_wstrb(O_s_wstrb), .O_s_wvalid(O_s_wvalid), .I_s_wready(I_s_wready),
        .I_s_bvalid(I_s_bvalid), .O_s_bready(O_s_bready)
    );

    always #5 I_clk = !I_clk;

    // slave: word index addr[6:3], read data one cycle after AR, bvalid together with the W beat
    assign I_s_bvalid = O_s_wvalid && I_s_wready;
    always @(posedge I_clk) begin
        if (I_rst) begin
            I_s_rvalid <= 1'b0;
            I_s_rdata <= '0;
            for (int i = 0; i < 16; i++) mem[i] <= (i == 15) ? 64'd5 : 64'h1000 + 64'(i);
        end else begin
            if (I_s_rvalid && O_s_rready) I_s_rvalid <= 1'b0;
            if (O_s_arvalid && I_s_arready) begin
                I_s_rvalid <= !s_hold;
                I_s_rdata <= mem[O_s_araddr[6:3]];
            end
            if (O_s_wvalid && I_s_wready) mem[O_s_awaddr[6:3]] <= O_s_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pop(input bit m, input logic [63:0] d);
        exp_t e;
        if (rq.size() == 0) chk("rsp_unexp", 1, 0);
        else begin
            e = rq.pop_front();
            chk("rsp_mst", 64'(m), 64'(e.m));
            chk("rsp_data", d, e.d);
        end
    endtask

    always @(negedge I_clk) begin
        if (O_m0_rvalid && I_m0_rready) pop(1'b0, O_m0_rdata);
        if (O_m1_rvalid && I_m1_rready) pop(1'b1, O_m1_rdata);
    end

    function automatic logic [11:0] vr();
        return {O_m0_arready, O_m1_arready, O_m0_rvalid, O_m1_rvalid, O_s_arvalid, O_s_rready,
                O_m1_awready, O_s_awvalid, O_s_wvalid, O_m1_wready, O_s_bready, O_m1_bvalid};
    endfunction

    task automatic drain();
        int k;
        for (k = 0; k < 100 && rq.size() != 0; k++) @(negedge I_clk);
        chk("drain", 64'(rq.size()), 0);
    endtask

    task automatic rd(input bit m, input logic [31:0] a, input logic [63:0] d);
        int k;
        rq.push_back('{m, d});
        if (m) begin I_m1_arvalid = 1'b1; I_m1_araddr = a; end
        else begin I_m0_arvalid = 1'b1; I_m0_araddr = a; end
        for (k = 0; k < 50; k++) begin
            @(negedge I_clk);
            if (m ? O_m1_arready : O_m0_arready) break;
        end
        chk("ar_hs", 64'(k < 50), 1);
        @(posedge I_clk); #1;
        I_m0_arvalid = 1'b0;
        I_m1_arvalid = 1'b0;
        drain();
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input int bw);
        int k;
        I_m1_awvalid = 1'b1; I_m1_awaddr = a;
        I_m1_wvalid = 1'b1; I_m1_wdata = d; I_m1_wstrb = 8'hFF;
        I_m1_bready = (bw == 0);
        for (k = 0; k < 50; k++) begin
            @(negedge I_clk);
            if (O_m1_awready) break;
        end
        chk("aw_hs", 64'(k < 50), 1);
        chk("ar_blk", 64'(O_m0_arready), 0);
        @(posedge I_clk); #1 I_m1_awvalid = 1'b0;
        @(negedge I_clk);
        chk("s_awvalid", 64'(O_s_awvalid), 1);
        chk("s_awaddr", 64'(O_s_awaddr), 64'(a));
        chk("s_wv_early", 64'(O_s_wvalid), 0);
        @(negedge I_clk);
        chk("s_wvalid", 64'(O_s_wvalid), 1);
        chk("s_wdata", O_s_wdata, d);
        chk("s_wstrb", 64'(O_s_wstrb), 64'hFF);
        chk("m1_wready", 64'(O_m1_wready), 1);
        @(posedge I_clk); #1 I_m1_wvalid = 1'b0;
        @(negedge I_clk);
        chk("bvalid", 64'(O_m1_bvalid), 1);
        for (int i = 0; i < bw; i++) begin
            @(negedge I_clk);
            chk("bvalid_hold", 64'(O_m1_bvalid), 1);
            chk("aw_blk_b", 64'(O_m1_awready), 0);
            chk("ar_blk_b", 64'(O_m0_arready), 0);
        end
        if (bw != 0) begin
            @(posedge I_clk); #1 I_m1_bready = 1'b1;
            @(negedge I_clk);
            chk("bvalid_hs", 64'(O_m1_bvalid), 1);
        end
        @(negedge I_clk);
        chk("bvalid_drop", 64'(O_m1_bvalid), 0);
    endtask

    task automatic reset();
        @(posedge I_clk); #1 I_rst = 1'b1;
        repeat (2) @(posedge I_clk);
        #1 I_rst = 1'b0;
        @(posedge I_clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, k;
        // reset: outputs quiet while asserted and one cycle after, even with requests pending
        I_m0_arvalid = 1'b1;
        I_m1_awvalid = 1'b1;
        @(posedge I_clk); #1;
        @(negedge I_clk);
        chk("rst_vr", 64'(vr()), 0);
        chk("rst_rdata", O_m0_rdata | O_m1_rdata, 0);
        @(posedge I_clk); #1 I_rst = 1'b0;
        @(negedge I_clk);
        chk("rst1_vr", 64'(vr()), 0);
        @(posedge I_clk); #1 I_m0_arvalid = 1'b0; I_m1_awvalid = 1'b0;
        @(negedge I_clk);
        chk("idle_awready", 64'(O_m1_awready), 1);
        chk("idle_s_arvalid", 64'(O_s_arvalid), 0);

        // M0 alone reads mtime: rvalid two cycles after AR handshake
        @(posedge I_clk); #1;
        rq.push_back('{1'b0, 64'd5});
        I_m0_arvalid = 1'b1; I_m0_araddr = 32'h0200_BFF8;
        @(negedge I_clk);
        chk("m0_arready_c0", 64'(O_m0_arready), 1);
        chk("m1_arready_c0", 64'(O_m1_arready), 0);
        @(posedge I_clk); #1 I_m0_arvalid = 1'b0;
        @(negedge I_clk);
        chk("s_arvalid_c1", 64'(O_s_arvalid), 1);
        chk("s_araddr_c1", 64'(O_s_araddr), 64'h0200_BFF8);
        chk("m0_rvalid_c1", 64'(O_m0_rvalid), 0);
        @(negedge I_clk);
        chk("m0_rvalid_c2", 64'(O_m0_rvalid), 1);
        chk("m0_rdata_c2", O_m0_rdata, 64'd5);
        chk("m1_rvalid_c2", 64'(O_m1_rvalid), 0);
        chk("m1_rdata_c2", O_m1_rdata, 0);
        drain();

        // round robin from reset: M0, M1, M0, M1
        reset();
        rq.push_back('{1'b0, 64'h1001});
        rq.push_back('{1'b1, 64'h1002});
        rq.push_back('{1'b0, 64'h1001});
        rq.push_back('{1'b1, 64'h1002});
        I_m0_araddr = 32'h0200_0008; I_m1_araddr = 32'h0200_0010;
        I_m0_arvalid = 1'b1; I_m1_arvalid = 1'b1;
        hs = 0;
        for (k = 0; k < 400 && hs < 4; k++) begin
            @(negedge I_clk);
            if (O_m0_arready || O_m1_arready) begin
                hs++;
                chk("rr_order", 64'(O_m1_arready), 64'(hs % 2 == 0));
            end
        end
        chk("rr_count", 64'(hs), 4);
        @(posedge I_clk); #1 I_m0_arvalid = 1'b0; I_m1_arvalid = 1'b0;
        drain();

        // M1 write then read back
        @(posedge I_clk); #1;
        wr(32'h0200_4000, 64'h64, 0);
        @(posedge I_clk); #1;
        rd(1'b1, 32'h0200_4000, 64'h64);

        // simultaneous M1 AW and M0 AR: write first, then the read
        @(posedge I_clk); #1;
        rq.push_back('{1'b0, 64'h1004});
        I_m0_arvalid = 1'b1; I_m0_araddr = 32'h0200_0020;
        wr(32'h0200_0028, 64'hDEAD_BEEF_0000_0005, 0);
        chk("ar_after_w", 64'(O_m0_arready), 1);
        @(posedge I_clk); #1 I_m0_arvalid = 1'b0;
        drain();

        // M1 stalls B for 5 cycles with an M0 read pending
        @(posedge I_clk); #1;
        rq.push_back('{1'b0, 64'hDEAD_BEEF_0000_0005});
        I_m0_arvalid = 1'b1; I_m0_araddr = 32'h0200_0028;
        wr(32'h0200_0030, 64'h77, 5);
        chk("ar_after_bstall", 64'(O_m0_arready), 1);
        @(posedge I_clk); #1 I_m0_arvalid = 1'b0;
        drain();

        // reset while waiting in R_DATA abandons the read
        @(posedge I_clk); #1;
        s_hold = 1'b1;
        I_m1_arvalid = 1'b1; I_m1_araddr = 32'h0200_0018;
        @(negedge I_clk);
        chk("rst_t_arready", 64'(O_m1_arready), 1);
        @(posedge I_clk); #1 I_m1_arvalid = 1'b0;
        @(negedge I_clk);
        chk("rst_t_s_arvalid", 64'(O_s_arvalid), 1);
        @(negedge I_clk);
        chk("rst_t_rdata_wait", 64'(O_m1_rvalid), 0);
        chk("rst_t_s_rready", 64'(O_s_rready), 1);
        @(posedge I_clk); #1 I_rst = 1'b1; I_m0_arvalid = 1'b1;
        @(negedge I_clk);
        chk("mid_rst_vr", 64'(vr()), 0);
        @(posedge I_clk); #1 I_rst = 1'b0; s_hold = 1'b0;
        @(negedge I_clk);
        chk("mid_rst1_vr", 64'(vr()), 0);
        chk("mid_rst1_rdata", O_m0_rdata | O_m1_rdata, 0);
        @(posedge I_clk); #1 I_m0_arvalid = 1'b0;
        rd(1'b1, 32'h0200_0018, 64'h1003);
        repeat (5) @(negedge I_clk);
        chk("final_q", 64'(rq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
